// File: rtl/m_data_mem_pkg.sv
// Shared constants for the M-stage data memory: load/store opcodes, access sizes
// and the pc value that the pipeline registers and the write log reset to.
package m_data_mem_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_W,
        SZ_H,
        SZ_B
    } access_size_t;

endpackage

// File: rtl/m_data_mem_lane_ctrl.sv
// Opcode and low address bits to access size, byte enables, sign handling and
// alignment; shared by the store merge path and the load extender.
module dm_lane_ctrl
    import m_data_mem_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [1:0]   i_addr_lo,
    output access_size_t o_size,
    output logic         o_is_load,
    output logic         o_is_store,
    output logic         o_sign_ext,
    output logic [3:0]   o_be,
    output logic         o_misalign
);

    always_comb begin
        o_size     = SZ_NONE;
        o_is_load  = 1'b0;
        o_is_store = 1'b0;
        o_sign_ext = 1'b0;
        case (i_opcode)
            OP_LW:   begin o_size = SZ_W; o_is_load  = 1'b1; end
            OP_LH:   begin o_size = SZ_H; o_is_load  = 1'b1; o_sign_ext = 1'b1; end
            OP_LHU:  begin o_size = SZ_H; o_is_load  = 1'b1; end
            OP_LB:   begin o_size = SZ_B; o_is_load  = 1'b1; o_sign_ext = 1'b1; end
            OP_LBU:  begin o_size = SZ_B; o_is_load  = 1'b1; end
            OP_SW:   begin o_size = SZ_W; o_is_store = 1'b1; end
            OP_SH:   begin o_size = SZ_H; o_is_store = 1'b1; end
            OP_SB:   begin o_size = SZ_B; o_is_store = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        o_be       = 4'b0000;
        o_misalign = 1'b0;
        case (o_size)
            SZ_W: begin
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            SZ_H: begin
                o_be       = 4'b0011 << i_addr_lo;
                o_misalign = i_addr_lo[0];
            end
            SZ_B: begin
                o_be       = 4'b0001 << i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_data_mem.sv
// M-stage data memory: combinational loads, single-cycle byte-enabled stores and a
// registered log of each committed store for the writeback/trace side.
module m_data_mem
    import m_data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_bad_addr,
    output logic        o_wlog_valid,
    output logic [31:0] o_wlog_pc,
    output logic [31:0] o_wlog_addr,
    output logic [31:0] o_wlog_data
);

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    logic [31:0]  mem_q [DEPTH_WORDS];
    logic         wlog_valid_q, wlog_valid_d;
    logic [31:0]  wlog_pc_q, wlog_pc_d;
    logic [31:0]  wlog_addr_q, wlog_addr_d;
    logic [31:0]  wlog_data_q, wlog_data_d;

    access_size_t size;
    logic         is_load, is_store, sign_ext, misalign;
    logic [3:0]   be;
    logic         in_range, bad, store_commit;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]  rd_word, rd_shifted, ld_ext, wr_rep, wr_word;
    logic         unused_instr;

    assign unused_instr = ^i_instr[25:0];

    dm_lane_ctrl u_lane_ctrl (
        .i_opcode   (i_instr[31:26]),
        .i_addr_lo  (i_addr[1:0]),
        .o_size     (size),
        .o_is_load  (is_load),
        .o_is_store (is_store),
        .o_sign_ext (sign_ext),
        .o_be       (be),
        .o_misalign (misalign)
    );

    assign in_range     = (i_addr[31:2] < DEPTH_LIM);
    assign word_idx     = i_addr[ADDR_W+1:2];
    assign bad          = (is_load || is_store) && (misalign || !in_range);
    assign store_commit = is_store && !bad;
    assign rd_word      = in_range ? mem_q[word_idx] : 32'h0;
    assign o_bad_addr   = bad;

    always_comb begin
        rd_shifted = rd_word >> {i_addr[1:0], 3'b000};
        case (size)
            SZ_H:    ld_ext = {{16{sign_ext & rd_shifted[15]}}, rd_shifted[15:0]};
            SZ_B:    ld_ext = {{24{sign_ext & rd_shifted[7]}}, rd_shifted[7:0]};
            default: ld_ext = rd_word;
        endcase
        o_rdata = (is_load && !bad) ? ld_ext : 32'h0;
    end

    // Narrow stores replicate their low bits into every lane; the enables pick the real ones.
    always_comb begin
        case (size)
            SZ_B:    wr_rep = {4{i_wdata[7:0]}};
            SZ_H:    wr_rep = {2{i_wdata[15:0]}};
            default: wr_rep = i_wdata;
        endcase
        for (int k = 0; k < 4; k++) begin
            wr_word[8*k +: 8] = be[k] ? wr_rep[8*k +: 8] : rd_word[8*k +: 8];
        end
    end

    always_comb begin
        wlog_valid_d = store_commit;
        wlog_pc_d    = store_commit ? i_pc : wlog_pc_q;
        wlog_addr_d  = store_commit ? {i_addr[31:2], 2'b00} : wlog_addr_q;
        wlog_data_d  = store_commit ? wr_word : wlog_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
            wlog_valid_q <= 1'b0;
            wlog_pc_q    <= PC_RESET;
            wlog_addr_q  <= 32'h0;
            wlog_data_q  <= 32'h0;
        end else begin
            if (store_commit) begin
                mem_q[word_idx] <= wr_word;
            end
            wlog_valid_q <= wlog_valid_d;
            wlog_pc_q    <= wlog_pc_d;
            wlog_addr_q  <= wlog_addr_d;
            wlog_data_q  <= wlog_data_d;
        end
    end

    assign o_wlog_valid = wlog_valid_q;
    assign o_wlog_pc    = wlog_pc_q;
    assign o_wlog_addr  = wlog_addr_q;
    assign o_wlog_data  = wlog_data_q;

endmodule

// File: tb/tb_m_data_mem.sv
// Scoreboard bench for m_data_mem: a byte-level reference memory produces the
// expected load data, bad-address flag and write log for every driven access.
module tb_m_data_mem;

    localparam int DEPTH = 3072;
    localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
    localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28, NOP = 6'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_pc, i_instr, i_addr, i_wdata;
    logic [31:0] o_rdata, o_wlog_pc, o_wlog_addr, o_wlog_data;
    logic        o_bad_addr, o_wlog_valid;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          num_compared = 0;
    int          num_mismatched = 0;

    logic [31:0] model_mem [DEPTH];
    logic        mlog_valid;
    logic [31:0] mlog_pc, mlog_addr, mlog_data;

    m_data_mem dut (
        .clk          (clk),
        .reset        (reset),
        .i_pc         (i_pc),
        .i_instr      (i_instr),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_bad_addr   (o_bad_addr),
        .o_wlog_valid (o_wlog_valid),
        .o_wlog_pc    (o_wlog_pc),
        .o_wlog_addr  (o_wlog_addr),
        .o_wlog_data  (o_wlog_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input logic [31:0] observed);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard-empty", 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observed, e.val);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        mlog_valid = 1'b0;
        mlog_pc    = 32'h3000;
        mlog_addr  = 32'h0;
        mlog_data  = 32'h0;
    endtask

    // Reference behaviour expressed byte by byte rather than via enables.
    task automatic modelEval(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic bad,
                             output logic store_ok, output logic [31:0] new_word);
        int nbytes;
        logic is_st, sx;
        logic [31:0] old;
        logic [31:0] raw;
        int lane;
        is_st = 1'b0; sx = 1'b0; nbytes = 0;
        case (op)
            LW: nbytes = 4;
            LH: begin nbytes = 2; sx = 1'b1; end
            LHU: nbytes = 2;
            LB: begin nbytes = 1; sx = 1'b1; end
            LBU: nbytes = 1;
            SW: begin nbytes = 4; is_st = 1'b1; end
            SH: begin nbytes = 2; is_st = 1'b1; end
            SB: begin nbytes = 1; is_st = 1'b1; end
            default: nbytes = 0;
        endcase
        rdata = 32'h0; bad = 1'b0; store_ok = 1'b0; new_word = 32'h0;
        if (nbytes != 0) begin
            bad = ((addr % nbytes) != 0) || ((addr / 4) >= DEPTH);
            if (!bad) begin
                old  = model_mem[addr / 4];
                lane = int'(addr % 4);
                if (is_st) begin
                    new_word = old;
                    for (int k = 0; k < nbytes; k++) new_word[8*(lane+k) +: 8] = wdata[8*k +: 8];
                    store_ok = 1'b1;
                end else begin
                    raw = old >> (8 * lane);
                    if (nbytes == 4) rdata = old;
                    else if (nbytes == 2) rdata = {(sx && raw[15]) ? 16'hFFFF : 16'h0, raw[15:0]};
                    else rdata = {(sx && raw[7]) ? 24'hFFFFFF : 24'h0, raw[7:0]};
                end
            end
        end
    endtask

    // Drives one M-stage instruction for one cycle; comb outputs are checked mid-cycle, the log after the edge.
    task automatic applyStimulus(input string name, input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc);
        logic [31:0] rdata, new_word;
        logic bad, store_ok;
        i_instr = {op, 26'h155_5555};
        i_addr  = addr;
        i_wdata = wdata;
        i_pc    = pc;
        modelEval(op, addr, wdata, rdata, bad, store_ok, new_word);
        exp_q.push_back('{$sformatf("%s rdata", name), rdata});
        exp_q.push_back('{$sformatf("%s bad_addr", name), {31'h0, bad}});
        if (store_ok) begin
            model_mem[addr / 4] = new_word;
            mlog_pc   = pc;
            mlog_addr = addr & ~32'h3;
            mlog_data = new_word;
        end
        mlog_valid = store_ok;
        exp_q.push_back('{$sformatf("%s wlog_valid", name), {31'h0, mlog_valid}});
        exp_q.push_back('{$sformatf("%s wlog_pc", name), mlog_pc});
        exp_q.push_back('{$sformatf("%s wlog_addr", name), mlog_addr});
        exp_q.push_back('{$sformatf("%s wlog_data", name), mlog_data});
        @(negedge clk);
        popCheck(o_rdata);
        popCheck({31'h0, o_bad_addr});
        @(posedge clk);
        #1;
        popCheck({31'h0, o_wlog_valid});
        popCheck(o_wlog_pc);
        popCheck(o_wlog_addr);
        popCheck(o_wlog_data);
    endtask

    initial begin
        reset   = 1'b1;
        i_pc    = 32'h0;
        i_instr = 32'h0;
        i_addr  = 32'h0;
        i_wdata = 32'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset wlog_valid", {31'h0, o_wlog_valid}, 32'h0);
        checkOutput("reset wlog_pc", o_wlog_pc, 32'h3000);
        checkOutput("reset wlog_addr", o_wlog_addr, 32'h0);
        checkOutput("reset wlog_data", o_wlog_data, 32'h0);

        applyStimulus("lw0",      LW,  32'h0,  32'h0,        32'h3000);
        applyStimulus("sw10",     SW,  32'h10, 32'h12345678, 32'h3004);
        applyStimulus("lw10",     LW,  32'h10, 32'h0,        32'h3008);
        applyStimulus("sb13",     SB,  32'h13, 32'h123456AB, 32'h300C);
        applyStimulus("lb13",     LB,  32'h13, 32'h0,        32'h3010);
        applyStimulus("lbu13",    LBU, 32'h13, 32'h0,        32'h3014);
        applyStimulus("sh12",     SH,  32'h12, 32'hFFFF8001, 32'h3018);
        applyStimulus("lh12",     LH,  32'h12, 32'h0,        32'h301C);
        applyStimulus("lhu12",    LHU, 32'h12, 32'h0,        32'h3020);
        applyStimulus("lw10b",    LW,  32'h10, 32'h0,        32'h3024);
        applyStimulus("lbu11",    LBU, 32'h11, 32'h0,        32'h3028);
        applyStimulus("sw11-mis", SW,  32'h11, 32'hDEADBEEF, 32'h302C);
        applyStimulus("lh11-mis", LH,  32'h11, 32'h0,        32'h3030);
        applyStimulus("sh13-mis", SH,  32'h13, 32'h0000BEEF, 32'h3034);
        applyStimulus("sw-oor",   SW,  32'h3000, 32'hCAFEF00D, 32'h3038);
        applyStimulus("lw-oor",   LW,  32'h3000, 32'h0,      32'h303C);
        applyStimulus("sb-top",   SB,  32'h2FFF, 32'h0000005A, 32'h3040);
        applyStimulus("lbu-top",  LBU, 32'h2FFF, 32'h0,      32'h3044);
        applyStimulus("lw-top",   LW,  32'h2FFC, 32'h0,      32'h3048);
        applyStimulus("lw10c",    LW,  32'h10, 32'h0,        32'h304C);
        applyStimulus("nop",      NOP, 32'h11, 32'hFFFFFFFF, 32'h3050);
        applyStimulus("sb40",     SB,  32'h40, 32'h00000011, 32'h3054);
        applyStimulus("sb41",     SB,  32'h41, 32'h00000022, 32'h3058);
        applyStimulus("sh42",     SH,  32'h42, 32'h0000F00F, 32'h305C);
        applyStimulus("lw40",     LW,  32'h40, 32'h0,        32'h3060);
        applyStimulus("lb42",     LB,  32'h42, 32'h0,        32'h3064);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("rnd-sw", SW, 32'h100 + 32'(4 * i), $urandom, 32'h3100 + 32'(i));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus("rnd-lw", LW, 32'h100 + 32'(4 * i), 32'h0, 32'h3200 + 32'(i));
        end

        // Store in flight when reset arrives: reset is held across the edge so the write is dropped.
        i_instr = {SW, 26'h0};
        i_addr  = 32'h20;
        i_wdata = 32'hFFFFFFFF;
        i_pc    = 32'h3300;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        i_instr = {NOP, 26'h0};
        reset   = 1'b0;
        modelReset();
        checkOutput("rst-mid wlog_valid", {31'h0, o_wlog_valid}, {31'h0, mlog_valid});
        checkOutput("rst-mid wlog_pc", o_wlog_pc, mlog_pc);
        applyStimulus("lw20-after-rst", LW, 32'h20, 32'h0, 32'h3304);
        applyStimulus("lw10-after-rst", LW, 32'h10, 32'h0, 32'h3308);
        applyStimulus("sw24-after-rst", SW, 32'h24, 32'h0BADF00D, 32'h330C);
        applyStimulus("lw24-after-rst", LW, 32'h24, 32'h0, 32'h3310);

        if (exp_q.size() != 0) checkOutput("scoreboard-leftover", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
